branch_metric: RTL and testbench
================================

BRANCH_METRIC -- requirements
Module: branch_metric

Interface
REQ-001 Parameter MAX_K, default 512, maximum trellis block length in bits (power of 2).
REQ-002 Parameter LLR_W, default 16, LLR and branch-metric width in bits.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; latches k_len and begins a block; honoured only in IDLE.
REQ-006 k_len  input  $clog2(MAX_K)+1  block length K, legal range 1..MAX_K.
REQ-007 in_valid  input  1  LLR triple valid.
REQ-008 in_ready  output  1  module accepts the triple this cycle.
REQ-009 llr_sys, llr_par, llr_apri  input  LLR_W each, signed  systematic, parity and a-priori LLRs.
REQ-010 init_branch1, init_branch2  output  LLR_W, signed  branch metrics to the forward recursion.
REQ-011 valid_branch  output  1  branch metric strobe.
REQ-012 fsm_state  output  2  00 IDLE, 01 LOAD, 10 FWD, 11 BWD.
REQ-013 done  output  1  one-cycle pulse after the last BWD strobe.

Function
REQ-014 IDLE: in_ready=0, valid_branch=0; start moves to LOAD, clears the write address, and latches K.
REQ-015 LOAD: in_ready=1; each in_valid&in_ready beat writes the triple to buffer address wr_addr, then increments wr_addr.
REQ-016 LOAD -> FWD on the cycle after beat K is accepted; in_ready drops to 0 on that same cycle.
REQ-017 Metric arithmetic: s = llr_sys + llr_apri, sign-extended to LLR_W+2 bits.
REQ-018 init_branch1 = (s + llr_par) >>> 1, arithmetic shift.
REQ-019 init_branch2 = (s - llr_par) >>> 1, arithmetic shift.
REQ-020 Metrics are computed at buffer read and registered, so the read-to-output latency is 2 cycles.
REQ-021 FWD reads addresses 0..K-1 in ascending order.
REQ-022 FWD cadence: valid_branch is high on alternate cycles (1,0,1,0,...), giving the downstream recursion a commit cycle after every update.
REQ-023 Metric outputs hold their value during the 0 cycle of the cadence.
REQ-024 FWD -> BWD after the K-th strobe plus its trailing 0 cycle; BWD reads K-1..0 in descending order with the same cadence and latency.
REQ-025 After the final BWD strobe, done=1 for one cycle and fsm_state returns to IDLE.
REQ-026 start outside IDLE is ignored.
REQ-027 K=1: exactly one strobe in FWD and one in BWD.
REQ-028 K=MAX_K: the address counter does not wrap before the phase ends.
REQ-029 Outputs other than during a strobe: init_branch1/2 hold their last value; valid_branch=0.

Reset
REQ-030 rst low forces IDLE asynchronously: in_ready=0, valid_branch=0, done=0, init_branch1/2=0, fsm_state=00, counters=0.
REQ-031 Reset mid-block discards the block; no strobe or done is produced afterwards until a new start.
REQ-032 Buffer contents are not reset.

Configuration
REQ-033 Macro BRANCH_SAT_EN defined: metrics saturate to [-2^(LLR_W-1), 2^(LLR_W-1)-1].
REQ-034 Macro BRANCH_SAT_EN undefined: metrics are truncated to the low LLR_W bits (two's-complement wrap).

Structure
REQ-035 Package siso_pkg holds the fsm_state enum (IDLE/LOAD/FWD/BWD) and the LLR_W and MAX_K defaults.
REQ-036 One sub-module, bm_buf: single-port MAX_K x 3*LLR_W synchronous RAM with 1-cycle read latency; arithmetic stays in branch_metric.

Verification
REQ-037 Reset test: rst low during FWD -> next cycle fsm_state=00, valid_branch=0, no done.
REQ-038 K=4, sys=10/20/30/40, par=2, apri=0 -> FWD branch1=6,11,16,21 and branch2=4,9,14,19; BWD gives the same values in reverse order; strobes alternate 1,0; done=1 once.
REQ-039 Negative odd sum: sys=-3, par=0, apri=0 -> branch1=branch2=-2 (arithmetic floor).
REQ-040 sys=32767, apri=32767, par=32767: with BRANCH_SAT_EN, branch1=32767; without it, branch1=the low 16 bits of 49150 = 0xBFFE.
REQ-041 K=1 plus a start pulse during LOAD -> start ignored, exactly 2 strobes, done=1.
REQ-042 in_valid toggled randomly in LOAD with K=MAX_K -> all 512 beats stored in order; FWD address 511 outputs the last beat.

Source files
------------

// File: rtl/siso_pkg.sv
// rtl/siso_pkg.sv - shared FSM state encoding and default sizes for the branch-metric slice
package siso_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    FWD  = 2'b10,
    BWD  = 2'b11
  } fsm_state_e;

  localparam int LLR_W_DEF = 16;
  localparam int MAX_K_DEF = 512;
endpackage

// File: rtl/bm_buf.sv
// rtl/bm_buf.sv - single-port LLR triple buffer, synchronous read with one cycle of latency
module bm_buf #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 48
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Contents are deliberately left unreset; a block is always written before it is read.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/branch_metric.sv
// rtl/branch_metric.sv - buffers a block of LLR triples and replays branch metrics forward then backward
// Optional saturation of the metrics is enabled by defining BRANCH_SAT_EN.
module branch_metric
  import siso_pkg::*;
#(
  parameter int MAX_K = MAX_K_DEF,
  parameter int LLR_W = LLR_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [$clog2(MAX_K):0]   k_len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [LLR_W-1:0]  llr_sys,
  input  logic signed [LLR_W-1:0]  llr_par,
  input  logic signed [LLR_W-1:0]  llr_apri,
  output logic signed [LLR_W-1:0]  init_branch1,
  output logic signed [LLR_W-1:0]  init_branch2,
  output logic                     valid_branch,
  output logic [1:0]               fsm_state,
  output logic                     done
);
  localparam int AW = $clog2(MAX_K);
  localparam int KW = AW + 1;
  localparam int CW = AW + 2;
  localparam int SW = LLR_W + 2;

  fsm_state_e              r_state;
  logic [KW-1:0]           r_k;
  logic [AW-1:0]           r_wr_addr;
  logic [CW-1:0]           r_cnt;
  logic                    r_in_ready;
  logic                    r_rd_vld;
  logic                    r_valid;
  logic                    r_done;
  logic signed [LLR_W-1:0] r_b1;
  logic signed [LLR_W-1:0] r_b2;

  logic                    w_wr_en;
  logic                    w_rd_en;
  logic                    w_phase_end;
  logic [KW-1:0]           w_kmax;
  logic [AW-1:0]           w_idx;
  logic [AW-1:0]           w_rd_addr;
  logic [AW-1:0]           w_addr;
  logic [3*LLR_W-1:0]      w_rdata;

  assign w_wr_en     = in_valid && r_in_ready;
  assign w_kmax      = r_k - KW'(1);
  assign w_phase_end = (r_cnt == {r_k, 1'b1});
  // Phase cycle counter: even cycles issue a read, odd cycles are the downstream commit gap.
  assign w_rd_en     = ((r_state == FWD) || (r_state == BWD)) && !r_cnt[0] && (r_cnt[CW-1:1] < r_k);
  assign w_idx       = r_cnt[AW:1];
  assign w_rd_addr   = (r_state == FWD) ? w_idx : (w_kmax[AW-1:0] - w_idx);
  assign w_addr      = (r_state == LOAD) ? r_wr_addr : w_rd_addr;

  bm_buf #(
    .DEPTH(MAX_K),
    .WIDTH(3*LLR_W)
  ) u_buf (
    .clk    (clk),
    .i_we   (w_wr_en),
    .i_re   (w_rd_en),
    .i_addr (w_addr),
    .i_wdata({llr_apri, llr_par, llr_sys}),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_k        <= '0;
      r_wr_addr  <= '0;
      r_cnt      <= '0;
      r_in_ready <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= LOAD;
            r_k        <= k_len;
            r_wr_addr  <= '0;
            r_in_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (w_wr_en) begin
            r_wr_addr <= r_wr_addr + AW'(1);
            if ({1'b0, r_wr_addr} == w_kmax) begin
              r_state    <= FWD;
              r_in_ready <= 1'b0;
              r_cnt      <= '0;
            end
          end
        end
        FWD: begin
          if (w_phase_end) begin
            r_state <= BWD;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        BWD: begin
          if (r_cnt == {r_k, 1'b0}) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  logic signed [LLR_W-1:0] w_sys, w_par, w_apri;
  logic signed [SW-1:0]    w_s, w_sum1, w_sum2;
  logic signed [LLR_W-1:0] w_b1, w_b2;

  assign w_sys  = w_rdata[LLR_W-1:0];
  assign w_par  = w_rdata[2*LLR_W-1:LLR_W];
  assign w_apri = w_rdata[3*LLR_W-1:2*LLR_W];
  assign w_s    = {{2{w_sys[LLR_W-1]}}, w_sys} + {{2{w_apri[LLR_W-1]}}, w_apri};
  assign w_sum1 = w_s + {{2{w_par[LLR_W-1]}}, w_par};
  assign w_sum2 = w_s - {{2{w_par[LLR_W-1]}}, w_par};

`ifdef BRANCH_SAT_EN
  localparam logic signed [SW-1:0] SAT_HI = SW'((2 ** (LLR_W - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_LO = -SAT_HI - SW'(1);

  function automatic logic [LLR_W-1:0] sat_fit(input logic signed [SW-1:0] v);
    if (v > SAT_HI) begin
      sat_fit = SAT_HI[LLR_W-1:0];
    end else if (v < SAT_LO) begin
      sat_fit = SAT_LO[LLR_W-1:0];
    end else begin
      sat_fit = v[LLR_W-1:0];
    end
  endfunction

  assign w_b1 = sat_fit(w_sum1 >>> 1);
  assign w_b2 = sat_fit(w_sum2 >>> 1);
`else
  logic w_unused;
  assign w_b1     = w_sum1[LLR_W:1];
  assign w_b2     = w_sum2[LLR_W:1];
  assign w_unused = ^{w_sum1[0], w_sum1[SW-1], w_sum2[0], w_sum2[SW-1]};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_vld <= 1'b0;
      r_valid  <= 1'b0;
      r_b1     <= '0;
      r_b2     <= '0;
    end else begin
      r_rd_vld <= w_rd_en;
      r_valid  <= r_rd_vld;
      if (r_rd_vld) begin
        r_b1 <= w_b1;
        r_b2 <= w_b2;
      end
    end
  end

  assign in_ready     = r_in_ready;
  assign valid_branch = r_valid;
  assign init_branch1 = r_b1;
  assign init_branch2 = r_b2;
  assign fsm_state    = r_state;
  assign done         = r_done;
endmodule

// File: tb/tb_branch_metric.sv
// tb/tb_branch_metric.sv - randomized scoreboard bench for branch_metric
module tb_branch_metric;
  localparam int MAX_K = 512;
  localparam int LLR_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [9:0]        k_len = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [15:0] llr_sys = '0, llr_par = '0, llr_apri = '0;
  logic signed [15:0] init_branch1, init_branch2;
  logic              valid_branch;
  logic [1:0]        fsm_state;
  logic              done;

  branch_metric #(.MAX_K(MAX_K), .LLR_W(LLR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .llr_sys(llr_sys), .llr_par(llr_par), .llr_apri(llr_apri),
    .init_branch1(init_branch1), .init_branch2(init_branch2),
    .valid_branch(valid_branch), .fsm_state(fsm_state), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic signed [15:0] b1; logic signed [15:0] b2; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int strobe_cnt = 0;
  int g_sys[MAX_K], g_par[MAX_K], g_apri[MAX_K];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: floor((sys +/- par + apri) / 2), then saturate or wrap to 16 bits.
  function automatic logic signed [15:0] ref_metric(input int sys, input int apri, input int par, input bit minus);
    int v, q;
    logic [31:0] qb;
    v = sys + apri + (minus ? -par : par);
    q = (v >= 0) ? v / 2 : -((-v + 1) / 2);
`ifdef BRANCH_SAT_EN
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
`endif
    qb = q;
    return qb[15:0];
  endfunction

  // Monitor: pops expectations on strobes, checks cadence and hold behaviour.
  initial begin
    logic prev_valid;
    logic signed [15:0] last_b1, last_b2;
    exp_t e;
    prev_valid = 1'b0; last_b1 = '0; last_b2 = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_valid = 1'b0; last_b1 = '0; last_b2 = '0;
      end else begin
        if (done) done_cnt++;
        if (valid_branch) begin
          strobe_cnt++;
          check("cadence_prev_zero", prev_valid, 0);
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_strobe actual=%0d,%0d required=none", init_branch1, init_branch2);
          end else begin
            e = exp_q.pop_front();
            check("branch1", init_branch1, e.b1);
            check("branch2", init_branch2, e.b2);
          end
          last_b1 = init_branch1; last_b2 = init_branch2;
        end else begin
          check("hold_branch1", init_branch1, last_b1);
          check("hold_branch2", init_branch2, last_b2);
        end
        prev_valid = valid_branch;
      end
    end
  end

  task automatic push_expect(input int k);
    exp_t e;
    for (int i = 0; i < k; i++) begin
      e.b1 = ref_metric(g_sys[i], g_apri[i], g_par[i], 1'b0);
      e.b2 = ref_metric(g_sys[i], g_apri[i], g_par[i], 1'b1);
      exp_q.push_back(e);
    end
    for (int i = k - 1; i >= 0; i--) begin
      e.b1 = ref_metric(g_sys[i], g_apri[i], g_par[i], 1'b0);
      e.b2 = ref_metric(g_sys[i], g_apri[i], g_par[i], 1'b1);
      exp_q.push_back(e);
    end
  endtask

  task automatic load_block(input int k, input bit rand_valid, input bit extra_start);
    int i, budget;
    bit acc;
    @(posedge clk); #2;
    start = 1'b1; k_len = 10'(k);
    @(posedge clk); #2;
    start = 1'b0;
    check("in_ready_load", in_ready, 1);
    i = 0; budget = 0;
    while (i < k && budget < 8 * MAX_K) begin
      in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      llr_sys = 16'(g_sys[i]); llr_par = 16'(g_par[i]); llr_apri = 16'(g_apri[i]);
      start = extra_start && (i == 0);
      k_len = extra_start ? 10'd7 : 10'(k);
      acc = in_valid && in_ready;
      @(posedge clk); #2;
      if (acc) i++;
      budget++;
    end
    in_valid = 1'b0; start = 1'b0;
    check("load_beats", i, k);
    check("fwd_entry_state", fsm_state, 2);
    check("fwd_entry_in_ready", in_ready, 0);
  endtask

  task automatic run_block(input int k, input bit rand_valid, input bit extra_start);
    int d0, s0, n;
    push_expect(k);
    d0 = done_cnt; s0 = strobe_cnt;
    load_block(k, rand_valid, extra_start);
    n = 0;
    while (done_cnt == d0 && n < 4 * k + 50) begin
      @(posedge clk); #2;
      n++;
    end
    repeat (4) @(posedge clk);
    #2;
    check("done_pulses", done_cnt - d0, 1);
    check("strobes", strobe_cnt - s0, 2 * k);
    check("queue_empty", exp_q.size(), 0);
    check("idle_after_done", fsm_state, 0);
    exp_q.delete();
  endtask

  task automatic fill_random(input int k);
    for (int i = 0; i < k; i++) begin
      g_sys[i]  = int'($signed(16'($urandom)));
      g_par[i]  = int'($signed(16'($urandom)));
      g_apri[i] = int'($signed(16'($urandom)));
    end
  endtask

  initial begin
    int d0, s0, n;
    #12;
    check("rst_state", fsm_state, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_valid", valid_branch, 0);
    check("rst_done", done, 0);
    check("rst_branch1", init_branch1, 0);
    check("rst_branch2", init_branch2, 0);
    @(posedge clk); #2;
    rst = 1'b1;

    for (int i = 0; i < 4; i++) begin
      g_sys[i] = 10 * (i + 1); g_par[i] = 2; g_apri[i] = 0;
    end
    run_block(4, 1'b0, 1'b0);

    g_sys[0] = -3; g_par[0] = 0; g_apri[0] = 0;
    run_block(1, 1'b0, 1'b0);

    g_sys[0] = 32767; g_par[0] = 32767; g_apri[0] = 32767;
    g_sys[1] = -32768; g_par[1] = 32767; g_apri[1] = -32768;
    run_block(2, 1'b0, 1'b0);

    fill_random(1);
    run_block(1, 1'b0, 1'b1);

    for (int b = 0; b < 4; b++) begin
      int k;
      k = $urandom_range(1, 24);
      fill_random(k);
      run_block(k, 1'b1, 1'b0);
    end

    fill_random(MAX_K);
    run_block(MAX_K, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) begin
      g_sys[i] = i; g_par[i] = 1; g_apri[i] = 0;
    end
    push_expect(4);
    load_block(4, 1'b0, 1'b0);
    d0 = done_cnt; s0 = strobe_cnt;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_state", fsm_state, 0);
    check("midrst_valid", valid_branch, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_branch1", init_branch1, 0);
    @(posedge clk); #2;
    rst = 1'b1;
    n = 0;
    repeat (30) @(posedge clk);
    #2;
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_no_strobe", strobe_cnt - s0, 0);
    check("midrst_idle", fsm_state, 0);

    fill_random(6);
    run_block(6, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
